// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer beside the EX-stage ALU; writes a 64-bit {HI,LO} result.
// Define MDU_MADD_EN to enable the MADD/MSUB accumulate ops (op 100/101).
module mdu_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo_i,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        hilo_we,
  output logic [63:0] hilo_o,
  output logic        div_zero
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  function automatic logic [63:0] mul64(input logic sgn, input logic [DATA_W-1:0] x,
                                        input logic [DATA_W-1:0] y);
    logic signed [65:0] xe;
    logic signed [65:0] ye;
    logic signed [65:0] p;
    xe = {{34{sgn & x[DATA_W-1]}}, x};
    ye = {{34{sgn & y[DATA_W-1]}}, y};
    p  = xe * ye;
    return p[63:0];
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic sgn, input logic [DATA_W-1:0] x);
    return (sgn && x[DATA_W-1]) ? (~x + DATA_W'(1)) : x;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] x);
    return neg ? (DATA_W'(0) - x) : x;
  endfunction

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              sgn_p0, madd_p0, sub_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [DATA_W-1:0] quo, rem, dvs;
  logic              op_legal, op_div, op_sgn, accept, div0;
  logic [DATA_W:0]   shifted;
  logic              ge;
  logic [DATA_W-1:0] quo_n, rem_n;
  logic [63:0]       prod, res;
  logic              res_dz;

  always_comb begin
`ifdef MDU_MADD_EN
    op_legal = (op[2:1] != 2'b11);
`else
    op_legal = ~op[2];
`endif
    op_div = (op[2:1] == 2'b01);
    op_sgn = ~op[0] | op[2];
    accept = start & (state == S_IDLE) & ~flush & op_legal;
    div0   = op_div & (b == '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_div)          state_n = div0 ? S_DONE : S_DIV;
          else if (MUL_LAT > 1) state_n = S_MUL;
          else                 state_n = op[2] ? S_FIX : S_DONE;
        end
      end
      S_MUL:   if (cnt == '0) state_n = madd_p0 ? S_FIX : S_DONE;
      S_DIV:   if (cnt == '0) state_n = S_FIX;
      S_FIX:   state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Flush beats everything, including a same-cycle start.
    if (flush) state_n = S_IDLE;
    done    = (state == S_DONE);
    busy    = resetn & (accept | (state inside {S_MUL, S_DIV, S_FIX}));
    hilo_we = resetn & done & ~flush;
  end

  // Restoring divide step on magnitudes, plus the result selected for the edge into DONE.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    ge      = (shifted >= {1'b0, dvs});
    rem_n   = ge ? DATA_W'(shifted - {1'b0, dvs}) : shifted[DATA_W-1:0];
    quo_n   = {quo[DATA_W-2:0], ge};
    prod    = mul64(sgn_p0, a_p0, b_p0);
    res     = hilo_o;
    res_dz  = 1'b0;
    case (state)
      S_IDLE: begin
        if (div0) begin
          res    = {a, {DATA_W{1'b1}}};
          res_dz = 1'b1;
        end else begin
          res = mul64(op_sgn, a, b);
        end
      end
      S_MUL: res = prod;
      S_FIX: begin
        if (madd_p0) res = sub_p0 ? (hilo_i - prod) : (hilo_i + prod);
        else         res = {cond_neg(sgn_p0 & a_p0[DATA_W-1], rem),
                            cond_neg(sgn_p0 & (a_p0[DATA_W-1] ^ b_p0[DATA_W-1]), quo)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt      <= '0;
      hilo_o   <= '0;
      div_zero <= 1'b0;
    end else begin
      if (accept)
        cnt <= op_div ? CNT_W'(DATA_W - 1) : CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
      else if ((state == S_MUL || state == S_DIV) && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (state_n == S_DONE) begin
        hilo_o   <= res;
        div_zero <= res_dz;
      end
    end
  end

  // Operand capture at accept; the divider iterates on quo/rem while in DIV.
  always_ff @(posedge clk) begin
    if (accept) begin
      sgn_p0  <= op_sgn;
      madd_p0 <= op[2];
      sub_p0  <= op[0];
      a_p0    <= a;
      b_p0    <= b;
      rem     <= '0;
      quo     <= mag(op_sgn, a);
      dvs     <= mag(op_sgn, b);
    end else if (state == S_DIV) begin
      rem <= rem_n;
      quo <= quo_n;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed, table-driven bench for mdu_ctrl with hand sequences for flush/reset/DONE-cycle cases.
// Define MDU_MADD_EN to also exercise MADD/MSUB.
module tb_mdu_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [63:0] hilo_i;
  logic        busy, done, hilo_we, div_zero;
  logic [63:0] hilo_o;
  logic [63:0] prev;
  int          checks = 0;
  int          failures = 0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .hilo_i(hilo_i), .flush(flush), .busy(busy), .done(done),
    .hilo_we(hilo_we), .hilo_o(hilo_o), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 of the cycle after DONE.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] hin,
                        input logic [63:0] exp_res, input logic exp_dz, input int exp_lat);
    int cyc, bcnt, wecnt;
    op = o; a = x; b = y; hilo_i = hin; start = 1'b1;
    #1;
    bcnt  = busy ? 1 : 0;
    wecnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (busy) bcnt++;
      if (hilo_we) wecnt++;
      @(posedge clk); #2;
      cyc++;
    end
    if (!done) begin
      chk({nm, "_done_timeout"}, 64'(done), 64'd1);
    end else begin
      chk({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({nm, "_hilo"}, hilo_o, exp_res);
      chk({nm, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
      chk({nm, "_hilo_we"}, 64'(hilo_we), 64'd1);
      chk({nm, "_busy_in_done"}, 64'(busy), 64'd0);
      chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
      chk({nm, "_early_we"}, 64'(wecnt), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic watch_no_done(input string nm, input int n);
    int c;
    c = 0;
    repeat (n) begin
      #1;
      if (done || hilo_we) c++;
      @(posedge clk); #1;
    end
    chk(nm, 64'(c), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 34};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 1'b0, 34};
    vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        64'hFFFFFFFF_FFFFFFFE, 1'b0, MUL_LAT};
    vecs[3]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE, 1'b0, MUL_LAT};
    vecs[4]  = '{3'd2, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF, 1'b1, 1};
    vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
    vecs[6]  = '{3'd3, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 1};
    vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, MUL_LAT};
    vecs[8]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, MUL_LAT};
    vecs[9]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
    vecs[10] = '{3'd3, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 34};
    vecs[11] = '{3'd2, 32'd100,      32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0, 34};

    // Reset with a pending start: busy must stay low, outputs clear.
    resetn = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0; a = 32'd5; b = 32'd3; hilo_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_we", 64'(hilo_we), 64'd0);
    chk("reset_hilo", hilo_o, 64'd0);
    chk("reset_div_zero", 64'(div_zero), 64'd0);
    start = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 64'd0,
             vecs[i].res, vecs[i].dz, vecs[i].lat);

    // Flush at DIV cycle 10: no write, idle next cycle, then a clean op.
    prev = hilo_o;
    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    chk("flush_div_busy", 64'(busy), 64'd1);
    chk("flush_div_we", 64'(hilo_we), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_div_busy_next", 64'(busy), 64'd0);
    chk("flush_div_done_next", 64'(done), 64'd0);
    chk("flush_div_hilo_kept", hilo_o, prev);
    watch_no_done("flush_div_no_done", 40);
    run_op("after_flush", 3'd2, 32'd100, 32'hFFFFFFF9, 64'd0, 64'h00000002_FFFFFFF2, 1'b0, 34);

    // Start presented in the DONE cycle is ignored.
    op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 3'd1; a = 32'd1; b = 32'd1; start = 1'b1;
    #1;
    chk("done_start_done", 64'(done), 64'd1);
    chk("done_start_busy", 64'(busy), 64'd0);
    chk("done_start_hilo", hilo_o, 64'd15);
    @(posedge clk); #1;
    start = 1'b0;
    watch_no_done("done_start_ignored", 6);

    // Flush during DONE keeps done but blocks the write.
    op = 3'd1; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    chk("flush_done_done", 64'(done), 64'd1);
    chk("flush_done_we", 64'(hilo_we), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_done_after", 64'(done), 64'd0);

    // Flush and start together: nothing accepted.
    op = 3'd3; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_busy_next", 64'(busy), 64'd0);
    watch_no_done("flush_start_no_done", 40);

`ifdef MDU_MADD_EN
    run_op("madd", 3'd4, 32'hFFFFFFFF, 32'd1, 64'h00000001_00000000,
           64'h00000000_FFFFFFFF, 1'b0, MUL_LAT + 1);
    run_op("msub", 3'd5, 32'd2, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, MUL_LAT + 1);
    op = 3'd6; a = 32'd2; b = 32'd3; start = 1'b1;
    #1;
    chk("illegal6_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    watch_no_done("illegal6_no_done", 6);
`else
    op = 3'd4; a = 32'hFFFFFFFF; b = 32'd1; hilo_i = 64'h00000001_00000000; start = 1'b1;
    #1;
    chk("madd_off_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    watch_no_done("madd_off_no_done", 6);
    op = 3'd6; start = 1'b1;
    #1;
    chk("illegal6_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    watch_no_done("illegal6_no_done", 6);
`endif

    // Reset in the middle of a divide clears outputs and abandons the op.
    run_op("pre_reset_div0", 3'd3, 32'h55, 32'd0, 64'd0, 64'h00000055_FFFFFFFF, 1'b1, 1);
    op = 3'd2; a = 32'd50; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0; op = 3'd0; start = 1'b1;
    #1;
    chk("midreset_busy_low", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("midreset_hilo", hilo_o, 64'd0);
    chk("midreset_div_zero", 64'(div_zero), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_we", 64'(hilo_we), 64'd0);
    resetn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    watch_no_done("midreset_no_done", 40);
    run_op("after_reset", 3'd0, 32'hFFFFFFFF, 32'd7, 64'd0, 64'hFFFFFFFF_FFFFFFF9, 1'b0, MUL_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
